l1_l2_arbiter_rr: RTL and testbench
===================================

Name: l1_l2_arbiter_rr

Overview:
Parametrised round-robin arbiter connecting NUM_CH L1 cache miss ports (icache, dcache, and any future prefetch/victim buffers) to the single L2 line port.
It is the next generation of the fixed two-port icache/dcache arbiter. Channel count, address width and line width are generic; fairness is a provable round-robin.
It owns the grant, routes the L2 handshake and dirty bit to exactly one channel per transaction, and enforces a turnaround cycle between grants.

Parameters:
NUM_CH, 2, number of L1 requester channels (>=2); channel 0 = icache, 1 = dcache by convention
ADDR_W, 16, address width (lc3b_word)
LINE_W, 128, cache line width (lc3b_cache_line)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
ch_address  in  NUM_CH*ADDR_W  per-channel line address, channel i at [i*ADDR_W +: ADDR_W]
ch_wdata  in  NUM_CH*LINE_W  per-channel writeback line
ch_read  in  NUM_CH  per-channel line read request
ch_write  in  NUM_CH  per-channel line write request
ch_dirty_out  in  NUM_CH  dirty bit sent from channel toward L2
ch_dirty_in  out  NUM_CH  dirty bit returned from L2 to channel
ch_rdata  out  LINE_W  L2 read line, broadcast to all channels
ch_resp  out  NUM_CH  one-hot completion pulse
l2_address  out  ADDR_W  L2 request address
l2_wdata  out  LINE_W  L2 write line
l2_read  out  1  L2 read strobe
l2_write  out  1  L2 write strobe
l2_dirty_out  out  1  dirty bit to L2
l2_rdata  in  LINE_W  L2 read line
l2_mem_resp  in  1  L2 completion
l2_dirty_in  in  1  dirty bit from L2

Behaviour:
- Channel request: req[i] = ch_read[i] | ch_write[i]. Requesters hold address, data and strobes stable until they see ch_resp[i].
- FSM states: IDLE, BUSY, TURN.
  - IDLE: if any req, register grant = first requesting channel strictly after last_grant (modulo NUM_CH), go to BUSY. Otherwise stay.
  - BUSY: l2_read/l2_write/l2_address/l2_wdata/l2_dirty_out = granted channel's signals, combinationally muxed. On l2_mem_resp: ch_resp[grant]=1 that same cycle, last_grant<=grant, go to TURN.
  - TURN: one cycle with all l2 strobes 0, so the completed channel can drop its request. Then go to IDLE.
- Latency: request seen in IDLE at cycle N gives l2 strobe at N+1. Back-to-back grants are spaced by at least 2 idle cycles on L2 (TURN + IDLE).
- Outside BUSY: l2_read=l2_write=0, l2_address=0, l2_wdata=0, l2_dirty_out=0, ch_resp=0.
- ch_resp[i] is asserted only when BUSY & l2_mem_resp & grant==i, so it is never multi-hot.
- ch_rdata = l2_rdata at all times.
- ch_dirty_in[i] = l2_dirty_in when grant==i, else 0.
- Fairness: with all channels requesting continuously, grants rotate 0,1,...,NUM_CH-1,0. Any requester is served within NUM_CH grants.
- Request dropped in BUSY (protocol violation): the strobe drops with it. The FSM stays in BUSY until l2_mem_resp; no recovery logic.
- ch_read and ch_write both high on one channel: both forwarded unchanged. L2 defines the precedence.
- l2_mem_resp outside BUSY is ignored.
- Reset (rst_n=0 at an edge, any state including mid-BUSY): state=IDLE, grant=0, last_grant=NUM_CH-1 so channel 0 wins first, all outputs at their idle values. An in-flight L2 transaction is abandoned; the L2 side is reset together with the arbiter.
- grant and last_grant are $clog2(NUM_CH) bits wide. The modular increment wraps explicitly at NUM_CH-1 to 0, which matters when NUM_CH is not a power of 2.

Decomposition:
- lc3b_types supplies lc3b_word and lc3b_cache_line. Add an arbiter state enum (ARB_IDLE, ARB_BUSY, ARB_TURN) to lc3b_types.
- Sub-module rr_picker (NUM_CH): purely combinational.
  - Inputs: req vector, last_grant.
  - Outputs: valid, next_grant index.
  - Verified standalone.

Test Plan:
- Single read, NUM_CH=2: ch_read=2'b01, ch_address[0]=16'h1230, L2 responds 3 cycles after strobe with l2_rdata=128'hA5.. → l2_read high from cycle 1; ch_resp=2'b01 for one cycle with ch_rdata=128'hA5..; TURN cycle with l2_read=0.
- Simultaneous requests after reset: ch0 read, ch1 write with ch_wdata[1]=128'h5A.. → ch0 granted first. ch1 granted after TURN+IDLE, with l2_write=1 and l2_wdata=128'h5A...
- Saturation, NUM_CH=3, all channels requesting forever → grant sequence 0,1,2,0,1,2; no channel waits more than 3 grants.
- Dirty routing: ch1 granted, ch_dirty_out[1]=1, l2_dirty_in=1 at resp → l2_dirty_out=1 during BUSY; ch_dirty_in=2'b10 during resp; ch_dirty_in[0]=0 throughout.
- Reset mid-BUSY: rst_n=0 for one edge while ch1 is granted → next cycle l2_read=0, ch_resp=0, state IDLE. With both requesting afterwards, ch0 wins.
- Stray l2_mem_resp=1 in IDLE/TURN → no ch_resp pulse, state unchanged.

Source files
------------

// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types
//
// Shared type definitions for the LC-3b memory hierarchy.
//
//   lc3b_word        16-bit machine word, also the line address type
//   lc3b_cache_line  128-bit cache line
//   arb_state_e      state of the L1->L2 round-robin arbiter
//   grant_w()        width of a channel index for a given channel count
// ---------------------------------------------------------------------------
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cache_line;

    // IDLE: waiting for a request.
    // BUSY: one channel owns the L2 port until l2_mem_resp.
    // TURN: one dead cycle so the served channel can drop its request
    //       before the next arbitration looks at it.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_TURN = 2'd2
    } arb_state_e;

    // A single-channel build still needs a 1-bit index.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//
// Combinational round-robin pick. Starting one past last_grant and moving
// upward with wrap-around, returns the first channel whose req bit is set.
// The channel that was served last is therefore considered last.
//
// Ports:
//   req         in   NUM_CH  request vector, one bit per channel
//   last_grant  in   GW      index of the most recently served channel
//   valid       out  1       at least one request is pending
//   next_grant  out  GW      winning channel index (0 when !valid)
// ---------------------------------------------------------------------------
module rr_picker
    import lc3b_types::*;
#(
    parameter int NUM_CH = 2,
    parameter int GW     = grant_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [GW-1:0]     last_grant,
    output logic              valid,
    output logic [GW-1:0]     next_grant
);

    always_comb begin
        logic [GW-1:0] idx;
        valid      = 1'b0;
        next_grant = '0;
        idx        = last_grant;
        // Visit every channel exactly once, ending at last_grant itself.
        // The wrap compares against NUM_CH-1 rather than relying on
        // natural overflow so non-power-of-two channel counts rotate
        // correctly.
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (idx >= GW'(NUM_CH - 1)) ? '0 : idx + GW'(1);
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                next_grant = idx;
            end
        end
    end

endmodule

// File: rtl/l1_l2_arbiter_rr.sv
// ---------------------------------------------------------------------------
// l1_l2_arbiter_rr
//
// Round-robin arbiter between NUM_CH L1 miss ports and the single L2 line
// port. One channel owns L2 per transaction; a dead TURN cycle separates
// consecutive grants.
//
// Handshake: a channel requests by raising ch_read and/or ch_write and holds
// address, write data, dirty bit and strobes stable until it sees its
// ch_resp bit high for one cycle. ch_resp[i] is the completion pulse; the
// channel may drop or change its request from the following cycle. On the
// L2 side the strobes stay up (combinationally following the granted
// channel) until l2_mem_resp, which is only honoured while BUSY.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   ch_address       in   NUM_CH*ADDR_W  channel i at [i*ADDR_W +: ADDR_W]
//   ch_wdata         in   NUM_CH*LINE_W  channel i at [i*LINE_W +: LINE_W]
//   ch_read/write    in   NUM_CH         per-channel line strobes
//   ch_dirty_out     in   NUM_CH         dirty bit toward L2
//   ch_dirty_in      out  NUM_CH         L2 dirty bit, granted channel only
//   ch_rdata         out  LINE_W         L2 read line, broadcast
//   ch_resp          out  NUM_CH         one-hot completion pulse
//   l2_address       out  ADDR_W         granted channel's address
//   l2_wdata         out  LINE_W         granted channel's write line
//   l2_read/write    out  1              granted channel's strobes
//   l2_dirty_out     out  1              granted channel's dirty bit
//   l2_rdata         in   LINE_W         L2 read line
//   l2_mem_resp      in   1              L2 completion
//   l2_dirty_in      in   1              dirty bit from L2
//   dbg_state        out  2              current arb_state_e encoding
// ---------------------------------------------------------------------------
module l1_l2_arbiter_rr
    import lc3b_types::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = $bits(lc3b_word),
    parameter int LINE_W = $bits(lc3b_cache_line)
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH-1:0]        ch_dirty_out,
    output logic [NUM_CH-1:0]        ch_dirty_in,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,

    output logic [ADDR_W-1:0]        l2_address,
    output logic [LINE_W-1:0]        l2_wdata,
    output logic                     l2_read,
    output logic                     l2_write,
    output logic                     l2_dirty_out,
    input  logic [LINE_W-1:0]        l2_rdata,
    input  logic                     l2_mem_resp,
    input  logic                     l2_dirty_in,

    output logic [1:0]               dbg_state
);

    localparam int GW = grant_w(NUM_CH);

    arb_state_e       state_q, state_d;
    logic [GW-1:0]    grant_q;
    logic [GW-1:0]    last_grant_q;
    logic [NUM_CH-1:0] req;
    logic             pick_valid;
    logic [GW-1:0]    pick_idx;
    int unsigned      gsel;

    assign req  = ch_read | ch_write;
    assign gsel = 32'(grant_q);

    rr_picker #(
        .NUM_CH (NUM_CH),
        .GW     (GW)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .next_grant (pick_idx)
    );

    // -----------------------------------------------------------------------
    // State and grant registers.
    // last_grant resets to NUM_CH-1 so the first pick after reset lands on
    // channel 0. grant only moves in IDLE, so it stays pointing at the
    // served channel through TURN; that keeps ch_dirty_in routing stable.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            if (state_q == ARB_IDLE && pick_valid) begin
                grant_q <= pick_idx;
            end
            if (state_q == ARB_BUSY && l2_mem_resp) begin
                last_grant_q <= grant_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state and L2-facing outputs.
    // Everything toward L2 is zero unless BUSY. While BUSY the strobes
    // follow the granted channel live: if a channel illegally drops its
    // request the strobe drops too, but the grant is held until L2 answers.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        l2_read      = 1'b0;
        l2_write     = 1'b0;
        l2_address   = '0;
        l2_wdata     = '0;
        l2_dirty_out = 1'b0;
        ch_resp      = '0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_BUSY;
                end
            end

            ARB_BUSY: begin
                l2_read      = ch_read[grant_q];
                l2_write     = ch_write[grant_q];
                l2_dirty_out = ch_dirty_out[grant_q];
                l2_address   = ch_address[gsel*ADDR_W +: ADDR_W];
                l2_wdata     = ch_wdata[gsel*LINE_W +: LINE_W];
                if (l2_mem_resp) begin
                    ch_resp[grant_q] = 1'b1;
                    state_d          = ARB_TURN;
                end
            end

            ARB_TURN: begin
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Read data is broadcast; each channel qualifies it with its ch_resp bit.
    assign ch_rdata = l2_rdata;

    // The L2 dirty bit only ever reaches the channel that holds the grant.
    always_comb begin
        ch_dirty_in = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_dirty_in[i] = (gsel == 32'(i)) ? l2_dirty_in : 1'b0;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_l1_l2_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_l1_l2_arbiter_rr
//
// Bench for a three-channel arbiter (non-power-of-two wrap). Time advances
// only through tick(): at the rising edge the reference model is updated,
// shortly after it the L2 responder reacts, and at the falling edge the
// outputs are compared with the model. Tests drive channel inputs at the
// falling edge after tick() returns.
// ---------------------------------------------------------------------------
module tb_l1_l2_arbiter_rr;
  import lc3b_types::*;

  localparam int NUM_CH = 3;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam int GW     = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NUM_CH*ADDR_W-1:0] ch_address;
  logic [NUM_CH*LINE_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH-1:0]        ch_dirty_out;
  logic [NUM_CH-1:0]        ch_dirty_in;
  logic [LINE_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]        ch_resp;
  logic [ADDR_W-1:0]        l2_address;
  logic [LINE_W-1:0]        l2_wdata;
  logic                     l2_read;
  logic                     l2_write;
  logic                     l2_dirty_out;
  logic [LINE_W-1:0]        l2_rdata;
  logic                     l2_mem_resp;
  logic                     l2_dirty_in;
  logic [1:0]               dbg_state;

  logic resp_auto;
  logic resp_force;
  assign l2_mem_resp = resp_auto | resp_force;

  l1_l2_arbiter_rr #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch_address   (ch_address),
    .ch_wdata     (ch_wdata),
    .ch_read      (ch_read),
    .ch_write     (ch_write),
    .ch_dirty_out (ch_dirty_out),
    .ch_dirty_in  (ch_dirty_in),
    .ch_rdata     (ch_rdata),
    .ch_resp      (ch_resp),
    .l2_address   (l2_address),
    .l2_wdata     (l2_wdata),
    .l2_read      (l2_read),
    .l2_write     (l2_write),
    .l2_dirty_out (l2_dirty_out),
    .l2_rdata     (l2_rdata),
    .l2_mem_resp  (l2_mem_resp),
    .l2_dirty_in  (l2_dirty_in),
    .dbg_state    (dbg_state)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en;

  // L2 responder settings
  int                l2_lat;
  int                l2_cnt;
  logic              resp_dirty;
  logic [LINE_W-1:0] rdata_pat;

  // Reference model: arbiter is either serving m_grant, cooling down for
  // m_cool cycles after a completion, or free to pick.
  bit m_busy;
  int m_cool;
  int m_last;
  int m_grant;

  // Scoreboard: channel expected to complete next, in order.
  logic [GW-1:0] exp_q[$];
  // Completions observed by the current test.
  int got_q[$];

  // ---------------- model ----------------
  task automatic model_update();
    logic [NUM_CH-1:0] r;
    r = ch_read | ch_write;
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_cool  = 0;
      m_last  = NUM_CH - 1;
      m_grant = 0;
      exp_q.delete();
    end else if (m_busy) begin
      if (l2_mem_resp) begin
        m_busy = 1'b0;
        m_cool = 1;
        m_last = m_grant;
      end
    end else if (m_cool > 0) begin
      m_cool = m_cool - 1;
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        int c;
        c = (m_last + k) % NUM_CH;
        if (!m_busy && r[c]) begin
          m_busy  = 1'b1;
          m_grant = c;
          exp_q.push_back(GW'(c));
        end
      end
    end
  endtask

  // ---------------- L2 responder ----------------
  task automatic l2_respond();
    if (!rst_n) begin
      resp_auto   = 1'b0;
      l2_cnt      = 0;
      l2_dirty_in = 1'b0;
    end else if (resp_auto) begin
      resp_auto   = 1'b0;
      l2_dirty_in = 1'b0;
    end else if (l2_read || l2_write) begin
      l2_cnt = l2_cnt + 1;
      if (l2_cnt >= l2_lat) begin
        resp_auto   = 1'b1;
        l2_cnt      = 0;
        l2_dirty_in = resp_dirty;
        l2_rdata    = rdata_pat;
      end
    end
  endtask

  // ---------------- output monitor + scoreboard ----------------
  task automatic monitor_checks();
    logic              e_rd, e_wr, e_do;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wd;
    logic [NUM_CH-1:0] e_resp, e_din, e_sb;
    logic [1:0]        e_st;
    logic [GW-1:0]     g;
    e_rd = 1'b0; e_wr = 1'b0; e_do = 1'b0;
    e_addr = '0; e_wd = '0; e_resp = '0; e_din = '0;
    if (m_busy) begin
      e_rd   = ch_read[m_grant];
      e_wr   = ch_write[m_grant];
      e_do   = ch_dirty_out[m_grant];
      e_addr = ch_address[m_grant*ADDR_W +: ADDR_W];
      e_wd   = ch_wdata[m_grant*LINE_W +: LINE_W];
      if (l2_mem_resp) e_resp[m_grant] = 1'b1;
    end
    e_din[m_grant] = l2_dirty_in;
    e_st = m_busy ? ARB_BUSY : ((m_cool > 0) ? ARB_TURN : ARB_IDLE);

    n_checks++;
    if (l2_read !== e_rd) begin n_fail++; $display("FAIL mon_l2_read t=%0t actual=%b expected=%b", $time, l2_read, e_rd); end
    n_checks++;
    if (l2_write !== e_wr) begin n_fail++; $display("FAIL mon_l2_write t=%0t actual=%b expected=%b", $time, l2_write, e_wr); end
    n_checks++;
    if (l2_dirty_out !== e_do) begin n_fail++; $display("FAIL mon_l2_dirty_out t=%0t actual=%b expected=%b", $time, l2_dirty_out, e_do); end
    n_checks++;
    if (l2_address !== e_addr) begin n_fail++; $display("FAIL mon_l2_address t=%0t actual=%h expected=%h", $time, l2_address, e_addr); end
    n_checks++;
    if (l2_wdata !== e_wd) begin n_fail++; $display("FAIL mon_l2_wdata t=%0t actual=%h expected=%h", $time, l2_wdata, e_wd); end
    n_checks++;
    if (ch_resp !== e_resp) begin n_fail++; $display("FAIL mon_ch_resp t=%0t actual=%b expected=%b", $time, ch_resp, e_resp); end
    n_checks++;
    if (ch_rdata !== l2_rdata) begin n_fail++; $display("FAIL mon_ch_rdata t=%0t actual=%h expected=%h", $time, ch_rdata, l2_rdata); end
    n_checks++;
    if (ch_dirty_in !== e_din) begin n_fail++; $display("FAIL mon_ch_dirty_in t=%0t actual=%b expected=%b", $time, ch_dirty_in, e_din); end
    n_checks++;
    if (dbg_state !== e_st) begin n_fail++; $display("FAIL mon_state t=%0t actual=%0d expected=%0d", $time, dbg_state, e_st); end

    if (ch_resp != '0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_resp t=%0t actual=%b expected=none", $time, ch_resp);
      end else begin
        g = exp_q.pop_front();
        e_sb = '0;
        e_sb[g] = 1'b1;
        if (ch_resp !== e_sb) begin
          n_fail++;
          $display("FAIL sb_order t=%0t actual=%b expected=%b", $time, ch_resp, e_sb);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #2;
    l2_respond();
    @(negedge clk);
    if (mon_en) monitor_checks();
  endtask

  // ---------------- driver helpers ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Run until n_resp completions are seen; drop each served request unless
  // hold is set. An expired budget counts as a failure.
  task automatic serve(input int n_resp, input int max_cyc, input bit hold);
    got_q.delete();
    for (int t = 0; t < max_cyc && got_q.size() < n_resp; t++) begin
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_resp[c]) begin
          got_q.push_back(c);
          if (!hold) begin
            ch_read[c]  = 1'b0;
            ch_write[c] = 1'b0;
          end
        end
      end
    end
    n_checks++;
    if (got_q.size() != n_resp) begin
      n_fail++;
      $display("FAIL serve_timeout actual=%0d expected=%0d completions", got_q.size(), n_resp);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (dbg_state !== 2'(ARB_IDLE)) begin n_fail++; $display("FAIL reset_state actual=%0d expected=%0d", dbg_state, ARB_IDLE); end
    n_checks++;
    if ({l2_read, l2_write, l2_dirty_out} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes actual=%b expected=000", {l2_read, l2_write, l2_dirty_out}); end
    n_checks++;
    if (ch_resp !== 3'b000) begin n_fail++; $display("FAIL reset_ch_resp actual=%b expected=000", ch_resp); end
    n_checks++;
    if (l2_address !== 16'h0000) begin n_fail++; $display("FAIL reset_l2_address actual=%h expected=0000", l2_address); end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (dbg_state !== 2'(ARB_IDLE)) begin n_fail++; $display("FAIL reset_idle_hold actual=%0d expected=%0d", dbg_state, ARB_IDLE); end
  endtask

  task automatic test_single_read();
    int waited;
    bit seen;
    ch_address[0*ADDR_W +: ADDR_W] = 16'h1230;
    ch_read[0] = 1'b1;
    l2_lat     = 3;
    rdata_pat  = {16{8'hA5}};
    tick();
    n_checks++;
    if (l2_read !== 1'b1 || l2_address !== 16'h1230) begin
      n_fail++; $display("FAIL single_first_strobe actual=%b/%h expected=1/1230", l2_read, l2_address);
    end
    seen = 1'b0; waited = 0;
    while (!seen && waited < 10) begin
      tick();
      waited++;
      if (ch_resp != '0) seen = 1'b1;
    end
    n_checks++;
    if (ch_resp !== 3'b001 || ch_rdata !== {16{8'hA5}}) begin
      n_fail++; $display("FAIL single_resp actual=%b/%h expected=001/a5..", ch_resp, ch_rdata);
    end
    n_checks++;
    if (waited != 2) begin n_fail++; $display("FAIL single_latency actual=%0d expected=2", waited); end
    ch_read[0] = 1'b0;
    tick();
    n_checks++;
    if (l2_read !== 1'b0 || dbg_state !== 2'(ARB_TURN) || ch_resp !== 3'b000) begin
      n_fail++; $display("FAIL single_turn actual=%b/%0d/%b expected=0/%0d/000", l2_read, dbg_state, ch_resp, ARB_TURN);
    end
    tick();
    n_checks++;
    if (dbg_state !== 2'(ARB_IDLE)) begin n_fail++; $display("FAIL single_back_idle actual=%0d expected=%0d", dbg_state, ARB_IDLE); end
  endtask

  task automatic test_back_to_back();
    int t_resp0, t_wr1;
    bit wd_checked;
    do_reset();
    l2_lat = 2;
    ch_address[0*ADDR_W +: ADDR_W] = 16'h0100;
    ch_address[1*ADDR_W +: ADDR_W] = 16'h0200;
    ch_wdata[1*LINE_W +: LINE_W]   = {16{8'h5A}};
    ch_read[0]  = 1'b1;
    ch_write[1] = 1'b1;
    got_q.delete();
    t_resp0 = -1; t_wr1 = -1; wd_checked = 1'b0;
    for (int t = 0; t < 40 && got_q.size() < 2; t++) begin
      tick();
      if (l2_write && t_wr1 < 0) begin
        t_wr1 = t;
        wd_checked = 1'b1;
        n_checks++;
        if (l2_wdata !== {16{8'h5A}} || l2_address !== 16'h0200) begin
          n_fail++; $display("FAIL b2b_write_payload actual=%h/%h expected=5a../0200", l2_wdata, l2_address);
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_resp[c]) begin
          if (got_q.size() == 0) t_resp0 = t;
          got_q.push_back(c);
          ch_read[c]  = 1'b0;
          ch_write[c] = 1'b0;
        end
      end
    end
    n_checks++;
    if (got_q.size() != 2 || got_q[0] != 0 || got_q[1] != 1) begin
      n_fail++; $display("FAIL b2b_order actual_count=%0d expected=2 (0 then 1)", got_q.size());
    end
    n_checks++;
    if (!wd_checked || (t_wr1 - t_resp0) != 3) begin
      n_fail++; $display("FAIL b2b_gap actual=%0d expected=3 cycles resp-to-strobe", t_wr1 - t_resp0);
    end
    settle(2);
  endtask

  task automatic test_saturation();
    do_reset();
    l2_lat = 1;
    ch_read = 3'b111;
    serve(6, 60, 1'b1);
    ch_read = 3'b000;
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) begin
        n_checks++;
        if (got_q[i] != i % NUM_CH) begin
          n_fail++; $display("FAIL sat_grant_%0d actual=%0d expected=%0d", i, got_q[i], i % NUM_CH);
        end
      end
    end
    settle(3);
  endtask

  task automatic test_dirty();
    bit seen, do_checked;
    l2_lat     = 2;
    resp_dirty = 1'b1;
    ch_address[1*ADDR_W +: ADDR_W] = 16'hBEE0;
    ch_dirty_out[1] = 1'b1;
    ch_read[1]      = 1'b1;
    seen = 1'b0; do_checked = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      n_checks++;
      if (ch_dirty_in[0] !== 1'b0) begin n_fail++; $display("FAIL dirty_ch0_leak actual=%b expected=0", ch_dirty_in[0]); end
      if (l2_read && !do_checked) begin
        do_checked = 1'b1;
        n_checks++;
        if (l2_dirty_out !== 1'b1) begin n_fail++; $display("FAIL dirty_out actual=%b expected=1", l2_dirty_out); end
      end
      if (ch_resp != '0) begin
        seen = 1'b1;
        n_checks++;
        if (ch_dirty_in !== 3'b010 || ch_resp !== 3'b010) begin
          n_fail++; $display("FAIL dirty_in_route actual=%b/%b expected=010/010", ch_dirty_in, ch_resp);
        end
      end
    end
    n_checks++;
    if (!seen || !do_checked) begin n_fail++; $display("FAIL dirty_timeout actual=%b%b expected=11", seen, do_checked); end
    ch_read[1] = 1'b0;
    ch_dirty_out[1] = 1'b0;
    resp_dirty = 1'b0;
    settle(2);
  endtask

  task automatic test_reset_mid_busy();
    bit busy_seen;
    l2_lat = 20;
    ch_read[1] = 1'b1;
    busy_seen = 1'b0;
    for (int t = 0; t < 10 && !busy_seen; t++) begin
      tick();
      if (l2_read) busy_seen = 1'b1;
    end
    n_checks++;
    if (!busy_seen) begin n_fail++; $display("FAIL midrst_no_grant actual=0 expected=1"); end
    rst_n      = 1'b0;
    ch_read[0] = 1'b1;
    l2_lat     = 2;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (l2_read !== 1'b0 || ch_resp !== 3'b000 || dbg_state !== 2'(ARB_IDLE)) begin
      n_fail++; $display("FAIL midrst_outputs actual=%b/%b/%0d expected=0/000/%0d", l2_read, ch_resp, dbg_state, ARB_IDLE);
    end
    serve(2, 30, 1'b0);
    n_checks++;
    if (got_q.size() != 2 || got_q[0] != 0 || got_q[1] != 1) begin
      n_fail++; $display("FAIL midrst_order actual_count=%0d expected=2 (0 then 1)", got_q.size());
    end
    settle(2);
  endtask

  task automatic test_stray_resp();
    resp_force = 1'b1;
    tick();
    n_checks++;
    if (ch_resp !== 3'b000 || dbg_state !== 2'(ARB_IDLE)) begin
      n_fail++; $display("FAIL stray_idle actual=%b/%0d expected=000/%0d", ch_resp, dbg_state, ARB_IDLE);
    end
    resp_force = 1'b0;
    tick();
    l2_lat = 1;
    ch_read[2] = 1'b1;
    serve(1, 10, 1'b0);
    resp_force = 1'b1;
    tick();
    n_checks++;
    if (ch_resp !== 3'b000 || dbg_state !== 2'(ARB_TURN)) begin
      n_fail++; $display("FAIL stray_turn actual=%b/%0d expected=000/%0d", ch_resp, dbg_state, ARB_TURN);
    end
    tick();
    n_checks++;
    if (ch_resp !== 3'b000 || dbg_state !== 2'(ARB_IDLE)) begin
      n_fail++; $display("FAIL stray_after_turn actual=%b/%0d expected=000/%0d", ch_resp, dbg_state, ARB_IDLE);
    end
    resp_force = 1'b0;
    settle(2);
  endtask

  task automatic test_random();
    int kind;
    bit done;
    for (int t = 0; t < 400; t++) begin
      tick();
      rdata_pat = {$urandom, $urandom, $urandom, $urandom};
      if (ch_resp != '0) begin
        l2_lat     = $urandom_range(1, 4);
        resp_dirty = 1'($urandom_range(0, 1));
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_resp[c]) begin
          ch_read[c] = 1'b0; ch_write[c] = 1'b0; ch_dirty_out[c] = 1'b0;
        end else if (!(ch_read[c] || ch_write[c]) && $urandom_range(0, 2) == 0) begin
          kind = $urandom_range(0, 2);
          ch_address[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
          ch_wdata[c*LINE_W +: LINE_W]   = {$urandom, $urandom, $urandom, $urandom};
          ch_dirty_out[c] = 1'($urandom_range(0, 1));
          ch_read[c]  = (kind != 1);
          ch_write[c] = (kind != 0);
        end
      end
    end
    done = 1'b0;
    for (int t = 0; t < 80 && !done; t++) begin
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_resp[c]) begin ch_read[c] = 1'b0; ch_write[c] = 1'b0; ch_dirty_out[c] = 1'b0; end
      end
      done = ((ch_read | ch_write) == '0) && !m_busy && (m_cool == 0);
    end
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL random_drain actual=pending expected=drained"); end
  endtask

  // ---------------- main ----------------
  initial begin
    rst_n        = 1'b0;
    ch_address   = '0;
    ch_wdata     = '0;
    ch_read      = '0;
    ch_write     = '0;
    ch_dirty_out = '0;
    resp_auto    = 1'b0;
    resp_force   = 1'b0;
    l2_rdata     = '0;
    l2_dirty_in  = 1'b0;
    l2_lat       = 2;
    l2_cnt       = 0;
    resp_dirty   = 1'b0;
    rdata_pat    = '0;
    mon_en       = 1'b1;

    test_reset();
    test_single_read();
    test_back_to_back();
    test_saturation();
    test_dirty();
    test_reset_mid_busy();
    test_stray_resp();
    test_random();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover actual=%0d expected=0 outstanding", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
